mux_lut_engine: RTL
===================

Name: mux_lut_engine

Overview:
- Parametrised, sequential successor to the fixed 4-input mux-implemented function.
- Evaluates an arbitrary K-input Boolean function as a 2^K:1 multiplexer over a programmable truth table.
- Double-buffered: an active table serves evaluations while a shadow table is loaded serially over a valid/ready handshake. The shadow table becomes active atomically on completion.
- Sits between the lab switch/stimulus logic and the display/checker stage.

Parameters:
- K, 4, number of function inputs (mux select width); legal range 2..6.
- RESET_TT, {2**K{1'b0}}, active truth table after reset; bit m is f for minterm m.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- cfg_valid  input  1  cfg_bit is presented.
- cfg_ready  output  1  engine accepts a config bit this cycle.
- cfg_bit  input  1  truth-table bit, minterm 0 first.
- cfg_abort  input  1  discard the partial load.
- in_valid  input  1  in_sel is valid.
- in_sel  input  K  function inputs; in_sel[K-1] is the MSB (a), in_sel[0] is the LSB.
- out_valid  output  1  f is valid.
- f  output  1  registered function value.
- tbl_loaded  output  1  at least one user table has been committed since reset.
- load_busy  output  1  a partial load is in progress.

Behaviour:
- Internal storage: TT_BITS = 2**K.
  - act_tt[TT_BITS-1:0] and shd_tt[TT_BITS-1:0].
  - bit_cnt, K+1 bits wide.
  - FSM states IDLE, LOAD, COMMIT.
- Reset (asynchronous, effective immediately, including mid-load):
  - act_tt=RESET_TT, shd_tt=0, bit_cnt=0, state=IDLE.
  - f=0, out_valid=0, tbl_loaded=0, load_busy=0, cfg_ready=1.
- Evaluation (1-cycle latency):
  - On each edge: out_valid<=in_valid.
  - If in_valid, f<=act_tt[in_sel]; otherwise f holds its value.
  - Evaluation is independent of the FSM and never stalls.
- Handshake:
  - A bit is accepted when cfg_valid && cfg_ready at the clock edge.
  - The accepted bit is written to shd_tt[bit_cnt], then bit_cnt increments.
  - cfg_ready=1 in IDLE and LOAD, 0 in COMMIT (combinational decode of state).
  - cfg_bit is ignored when not accepted.
- FSM transitions:
  - IDLE: accepted bit -> LOAD (bit_cnt becomes 1). If K... TT_BITS=1 is impossible since K>=2.
  - LOAD: accepted bit with bit_cnt==TT_BITS-1 -> COMMIT. Otherwise stay in LOAD.
  - LOAD: cfg_abort=1 -> IDLE with bit_cnt=0. act_tt is untouched. A bit offered in the abort cycle is dropped.
  - COMMIT (exactly one cycle): act_tt<=shd_tt, bit_cnt<=0, tbl_loaded<=1 (sticky until reset) -> IDLE.
  - cfg_abort in IDLE or COMMIT has no effect.
- Swap timing:
  - An evaluation sampled on the COMMIT edge uses the old act_tt.
  - The first evaluation using the new table is sampled on the following edge.
  - No mixed-table result is ever produced.
- load_busy=1 while state==LOAD.
- bit_cnt never exceeds TT_BITS-1 outside COMMIT; there is no wrap.
- Back-to-back loads:
  - A new bit may be accepted in the cycle right after COMMIT (IDLE, ready=1).
  - Peak throughput is TT_BITS bits per TT_BITS+1 cycles.

Decomposition:
- Shared package/header mux_lut_pkg holds:
  - localparams for FSM state encodings (ST_IDLE=2'd0, ST_LOAD=2'd1, ST_COMMIT=2'd2).
  - a clog2 helper function.
- One natural sub-module, mux_lut_mux: parametrised 2^K:1 combinational mux (table, sel -> y), instantiated for the evaluation path.
- The FSM, counter and registers stay in the top module.

Test Plan:
- Reset check:
  - Stimulus: assert rst_n=0 mid-cycle, release, then sweep in_sel 0..15 with in_valid=1 every cycle.
  - Required: outputs zero immediately on reset; cfg_ready=1, tbl_loaded=0; f=0 for every minterm (RESET_TT=0), each result 1 cycle after its in_sel.
- Full load and sweep:
  - Stimulus: stream 16'hA5C3 LSB first with cfg_valid=1 on 16 consecutive cycles, then sweep in_sel 0..15.
  - Required: cfg_ready=0 for one cycle after bit 15; tbl_loaded=1; f sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1.
- Gapped load with concurrent evaluation:
  - Stimulus: load 16'h6996 (4-input XOR) with cfg_valid toggling every other cycle, while continuously evaluating in_sel=4'b0001.
  - Required: f=bit1 of the old table (1 for A5C3) through the COMMIT edge; f=1 of new table from the next sample on; in_sel=4'b0011 then gives 0.
- Abort:
  - Stimulus: accept 7 bits, pulse cfg_abort.
  - Required: load_busy falls and act_tt is unchanged (sweep matches the prior table); a subsequent complete load of 16'hFFFE (OR) gives f=0 only at in_sel=0.
- Reset mid-load:
  - Stimulus: assert rst_n=0 after 10 accepted bits.
  - Required: load_busy=0, out_valid=0 and f=0 immediately; after release, sweep gives RESET_TT and tbl_loaded=0.
- K=3 instance:
  - Stimulus: load 8'hE8 (majority), sweep in_sel 0..7.
  - Required: f = 0,0,0,1,0,1,1,1; COMMIT follows the 8th accepted bit.

Source files
------------

// File: rtl/mux_lut_pkg.sv
// Shared definitions for the mux-based LUT engine: FSM encodings and helpers.
package mux_lut_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_LOAD   = 2'd1;
   localparam logic [1:0] ST_COMMIT = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE   = ST_IDLE,
      S_LOAD   = ST_LOAD,
      S_COMMIT = ST_COMMIT
   } state_t;

   // Ceiling log2, usable in constant expressions.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/mux_lut_mux.sv
// 2^K:1 combinational multiplexer over a truth table; sel picks the minterm.
module mux_lut_mux
   import mux_lut_pkg::*;
#(
   parameter int K = 4
) (
   input  logic [(1<<K)-1:0] tbl,
   input  logic [K-1:0]      sel,
   output logic              y
);

   assign y = tbl[sel];

endmodule

// File: rtl/mux_lut_engine.sv
// K-input Boolean function engine: evaluates through a mux over an active
// truth table while a shadow table is streamed in bit-serially, then swapped
// in atomically for one COMMIT cycle.
module mux_lut_engine
   import mux_lut_pkg::*;
#(
   parameter int                K        = 4,
   parameter logic [2**K-1:0]   RESET_TT = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         cfg_valid,
   output logic         cfg_ready,
   input  logic         cfg_bit,
   input  logic         cfg_abort,
   input  logic         in_valid,
   input  logic [K-1:0] in_sel,
   output logic         out_valid,
   output logic         f,
   output logic         tbl_loaded,
   output logic         load_busy
);

   localparam int TT_BITS = 2**K;
   // One extra bit so the counter can express TT_BITS during COMMIT.
   localparam int CNT_W   = clog2(TT_BITS) + 1;

   logic [TT_BITS-1:0] act_tt;
   logic [TT_BITS-1:0] shd_tt;
   logic [CNT_W-1:0]   bit_cnt;
   state_t             state;
   logic               mux_y;
   logic               accept;

   mux_lut_mux #(.K(K)) u_mux (
      .tbl (act_tt),
      .sel (in_sel),
      .y   (mux_y)
   );

   // The only cycle that cannot take a bit is the swap cycle.
   assign cfg_ready = (state != S_COMMIT);
   assign load_busy = (state == S_LOAD);
   assign accept    = cfg_valid && cfg_ready;

   // Evaluation path: one-cycle latency, independent of the loader.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         f         <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) f <= mux_y;
      end
   end

   // Loader FSM: serial fill of the shadow table, abort, and atomic swap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         act_tt     <= RESET_TT;
         shd_tt     <= '0;
         bit_cnt    <= '0;
         tbl_loaded <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  shd_tt[bit_cnt[K-1:0]] <= cfg_bit;
                  bit_cnt                <= bit_cnt + CNT_W'(1);
                  state                  <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (cfg_abort) begin
                  // Partial table is simply abandoned; act_tt never saw it.
                  bit_cnt <= '0;
                  state   <= S_IDLE;
               end else if (accept) begin
                  shd_tt[bit_cnt[K-1:0]] <= cfg_bit;
                  bit_cnt                <= bit_cnt + CNT_W'(1);
                  if (bit_cnt == CNT_W'(TT_BITS-1)) state <= S_COMMIT;
               end
            end
            S_COMMIT: begin
               // Evaluations sampled on this edge still read the old table.
               act_tt     <= shd_tt;
               bit_cnt    <= '0;
               tbl_loaded <= 1'b1;
               state      <= S_IDLE;
            end
            default: begin
               bit_cnt <= '0;
               state   <= S_IDLE;
            end
         endcase
      end
   end

endmodule
